// File: rtl/sram_ctl_pkg.sv
// Shared state encoding and width defaults for the packet SRAM control path.
package sram_ctl_pkg;

    localparam int ADDR_W_DEF    = 12;
    localparam int PORT_ID_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set search starting one above the last winner.
module rr_pick #(
    parameter int num_of_ports  = 16,
    parameter int port_id_width = 4
) (
    input  logic [num_of_ports-1:0]  req,
    input  logic [port_id_width-1:0] ptr,
    output logic [num_of_ports-1:0]  onehot,
    output logic [port_id_width-1:0] idx,
    output logic                     any
);

    logic [port_id_width-1:0] k;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        k      = '0;
        for (int i = 1; i <= num_of_ports; i++) begin
            k = port_id_width'((int'(ptr) + i) % num_of_ports);
            if (!any && req[k]) begin
                any       = 1'b1;
                onehot[k] = 1'b1;
                idx       = k;
            end
        end
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Packet-granular arbiter for the single-port packet SRAM: one writer,
// round-robin readers, read-data strobe aligned to the SRAM latency.
module sram_access_arbiter
    import sram_ctl_pkg::*;
#(
    parameter int num_of_ports    = 16,
    parameter int port_id_width   = PORT_ID_W_DEF,
    parameter int address_width   = ADDR_W_DEF,
    parameter int wr_starve_limit = 8,
    parameter int idle_timeout    = 32,
    parameter int sram_rd_latency = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_req,
    input  logic [address_width-1:0]              wr_addr,
    input  logic                                  wr_last,
    output logic                                  wr_gnt,
    input  logic [num_of_ports-1:0]               rd_req,
    input  logic [address_width*num_of_ports-1:0] rd_addr,
    input  logic [num_of_ports-1:0]               rd_last,
    output logic [num_of_ports-1:0]               rd_gnt,
    output logic [num_of_ports-1:0]               rd_data_vld,
    output logic                                  sram_en,
    output logic                                  sram_we,
    output logic [address_width-1:0]              sram_addr,
    output logic                                  abort,
    output logic                                  busy
);

    localparam int streak_w = $clog2(wr_starve_limit + 1);
    localparam int tmo_w    = $clog2(idle_timeout + 1);

    state_t                   state, state_nxt;
    logic [num_of_ports-1:0]  gnt_oh, pick_oh;
    logic [port_id_width-1:0] win_idx, rr_ptr, pick_idx;
    logic                     pick_any;
    logic [streak_w-1:0]      wr_streak;
    logic [tmo_w-1:0]         tmo_cnt;
    logic [address_width-1:0] rd_addr_sel, act_addr;
    logic                     rd_last_sel, act_req, act_last;
    logic                     beat, tmo_hit, pkt_end, to_abort, leave, wr_pick;

    logic [sram_rd_latency:0]                    pipe_vld;
    logic [sram_rd_latency:0][port_id_width-1:0] pipe_idx;

    rr_pick #(
        .num_of_ports (num_of_ports),
        .port_id_width(port_id_width)
    ) u_rr_pick (
        .req   (rd_req),
        .ptr   (rr_ptr),
        .onehot(pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        rd_addr_sel = '0;
        rd_last_sel = 1'b0;
        for (int i = 0; i < num_of_ports; i++) begin
            if (gnt_oh[i]) begin
                rd_addr_sel = rd_addr_sel | rd_addr[i*address_width +: address_width];
                rd_last_sel = rd_last_sel | rd_last[i];
            end
        end
    end

    always_comb begin
        act_req  = 1'b0;
        act_last = 1'b0;
        act_addr = wr_addr;
        unique case (state)
            ST_WR: begin
                act_req  = wr_req;
                act_last = wr_last;
            end
            ST_RD: begin
                act_req  = |(rd_req & gnt_oh);
                act_last = rd_last_sel;
                act_addr = rd_addr_sel;
            end
            default: ;
        endcase
    end

    // A last beat on the timeout cycle wins over the abort.
    assign beat     = act_req;
    assign tmo_hit  = (state != ST_IDLE) && (tmo_cnt == tmo_w'(idle_timeout));
    assign pkt_end  = beat & act_last;
    assign to_abort = tmo_hit & ~pkt_end;
    assign leave    = pkt_end | to_abort;
    assign wr_pick  = wr_req &&
                      ((wr_streak < streak_w'(wr_starve_limit)) || (rd_req == '0));

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (wr_pick)
                    state_nxt = ST_WR;
                else if (pick_any)
                    state_nxt = ST_RD;
            end
            ST_WR, ST_RD: begin
                if (leave)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            gnt_oh  <= '0;
            win_idx <= '0;
            abort   <= 1'b0;
        end else begin
            state <= state_nxt;
            abort <= to_abort;
            if (state == ST_IDLE && state_nxt == ST_RD) begin
                gnt_oh  <= pick_oh;
                win_idx <= pick_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_streak <= '0;
            rr_ptr    <= port_id_width'(num_of_ports - 1);
            tmo_cnt   <= '0;
        end else begin
            if (leave && state == ST_WR) begin
                if (wr_streak < streak_w'(wr_starve_limit))
                    wr_streak <= wr_streak + streak_w'(1);
            end else if ((leave && state == ST_RD) ||
                         (state == ST_IDLE && rd_req == '0)) begin
                wr_streak <= '0;
            end
            if (leave && state == ST_RD)
                rr_ptr <= win_idx;
            if (state == ST_IDLE || beat || leave)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + tmo_w'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_en   <= 1'b0;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            pipe_vld  <= '0;
            pipe_idx  <= '0;
        end else begin
            sram_en <= beat;
            if (beat) begin
                sram_we   <= (state == ST_WR);
                sram_addr <= act_addr;
            end
            // Stage 0 lines up with the sram_en read cycle.
            pipe_vld[0] <= beat && (state == ST_RD);
            pipe_idx[0] <= win_idx;
            for (int i = 1; i <= sram_rd_latency; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    always_comb begin
        rd_data_vld = '0;
        if (pipe_vld[sram_rd_latency])
            rd_data_vld[pipe_idx[sram_rd_latency]] = 1'b1;
    end

    assign wr_gnt = (state == ST_WR);
    assign rd_gnt = (state == ST_RD) ? gnt_oh : '0;
    assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: requester models push expected
// SRAM commands and read strobes, a negedge monitor pops and compares them.
module tb_sram_access_arbiter;

    localparam int NP = 16;
    localparam int AW = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_req = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic             wr_last = 1'b0;
    logic             wr_gnt;
    logic [NP-1:0]    rd_req = '0;
    logic [AW*NP-1:0] rd_addr = '0;
    logic [NP-1:0]    rd_last = '0;
    logic [NP-1:0]    rd_gnt;
    logic [NP-1:0]    rd_data_vld;
    logic             sram_en;
    logic             sram_we;
    logic [AW-1:0]    sram_addr;
    logic             abort;
    logic             busy;

    sram_access_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_last    (wr_last),
        .wr_gnt     (wr_gnt),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_last    (rd_last),
        .rd_gnt     (rd_gnt),
        .rd_data_vld(rd_data_vld),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .abort      (abort),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            c;
        logic          we;
        logic [AW-1:0] a;
    } cmd_t;

    typedef struct {
        int            c;
        logic [NP-1:0] v;
    } vld_t;

    cmd_t cmd_q[$];
    vld_t vld_q[$];
    cmd_t mon_c;
    vld_t mon_v;
    int   log_q[$];
    int   exp_log[$];

    int            cyc = 0;
    int            n_chk = 0;
    int            n_err = 0;
    int            end_cyc = -10;
    int            wr_pkts = 0;
    int            wr_len = 1;
    int            wr_beat = 0;
    logic [AW-1:0] wr_a = '0;
    int            rd_len = 1;
    int            rd_pkts[NP];
    int            rd_beat[NP];
    int            rd_cnt[NP];
    logic          rd_hold[NP];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        wr_req  = wr_pkts > 0;
        wr_addr = wr_a;
        wr_last = (wr_beat == wr_len - 1);
        for (int p = 0; p < NP; p++) begin
            rd_req[p]            = (rd_pkts[p] > 0) && !rd_hold[p];
            rd_addr[p*AW +: AW]  = AW'(p * 256 + rd_cnt[p]);
            rd_last[p]           = (rd_beat[p] == rd_len - 1);
        end
    endtask

    // One cycle: drive requests, record beats seen with the current grants.
    task automatic step();
        cmd_t c;
        vld_t v;
        drive();
        chk("gnt_onehot0", 64'($onehot0({wr_gnt, rd_gnt})), 64'd1);
        if (cyc == end_cyc + 1)
            chk("bubble", 64'({wr_gnt, rd_gnt}), 64'd0);
        if (wr_gnt && wr_req) begin
            c.c = cyc + 1; c.we = 1'b1; c.a = wr_addr;
            cmd_q.push_back(c);
            wr_a++;
            if (wr_last) begin
                wr_pkts--; wr_beat = 0; log_q.push_back(16); end_cyc = cyc;
            end else begin
                wr_beat++;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (rd_gnt[p] && rd_req[p]) begin
                c.c = cyc + 1; c.we = 1'b0; c.a = rd_addr[p*AW +: AW];
                cmd_q.push_back(c);
                v.c = cyc + 2; v.v = '0; v.v[p] = 1'b1;
                vld_q.push_back(v);
                rd_cnt[p]++;
                if (rd_last[p]) begin
                    rd_pkts[p]--; rd_beat[p] = 0; log_q.push_back(p); end_cyc = cyc;
                end else begin
                    rd_beat[p]++;
                end
            end
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            step();
            k++;
        end
        if (log_q.size() < n)
            chk("pkt_budget", 64'(log_q.size()), 64'(n));
    endtask

    task automatic wait_gnt(input int p, input int budget);
        int k = 0;
        while (!rd_gnt[p] && k < budget) begin
            step();
            k++;
        end
        if (!rd_gnt[p])
            chk("gnt_wait", 64'(rd_gnt), 64'(1) << p);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_count"}, 64'(log_q.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
            chk(tag, 64'(log_q[i]), 64'(exp_log[i]));
        log_q.delete();
        exp_log.delete();
    endtask

    task automatic clear_model();
        wr_pkts = 0; wr_beat = 0;
        for (int p = 0; p < NP; p++) begin
            rd_pkts[p] = 0; rd_beat[p] = 0; rd_hold[p] = 1'b0;
        end
        end_cyc = -10;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (sram_en) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", 64'(sram_en), 64'd0);
                end else begin
                    mon_c = cmd_q.pop_front();
                    chk("cmd_cycle", 64'(cyc), 64'(mon_c.c));
                    chk("cmd_we_addr", 64'({sram_we, sram_addr}), 64'({mon_c.we, mon_c.a}));
                end
            end else if (cmd_q.size() > 0 && cmd_q[0].c <= cyc) begin
                void'(cmd_q.pop_front());
                chk("cmd_missing", 64'(sram_en), 64'd1);
            end
            if (rd_data_vld != '0) begin
                chk("vld_onehot", 64'($onehot(rd_data_vld)), 64'd1);
                if (vld_q.size() == 0) begin
                    chk("vld_unexpected", 64'(rd_data_vld), 64'd0);
                end else begin
                    mon_v = vld_q.pop_front();
                    chk("vld_cycle", 64'(cyc), 64'(mon_v.c));
                    chk("vld_port", 64'(rd_data_vld), 64'(mon_v.v));
                end
            end else if (vld_q.size() > 0 && vld_q[0].c <= cyc) begin
                mon_v = vld_q.pop_front();
                chk("vld_missing", 64'(rd_data_vld), 64'(mon_v.v));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int p = 0; p < NP; p++) rd_cnt[p] = 0;
        clear_model();
        rst = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 64'({wr_gnt, rd_gnt, rd_data_vld, sram_en,
                                  sram_we, sram_addr, abort, busy}), 64'd0);
        rst = 1'b1;
        tick();

        // 3-beat write packet from 0x010
        wr_len = 3; wr_beat = 0; wr_a = 12'h010; wr_pkts = 1;
        drive();
        chk("wr_gnt_pre", 64'(wr_gnt), 64'd0);
        step();
        chk("wr_gnt_rise", 64'(wr_gnt), 64'd1);
        chk("busy_wr", 64'(busy), 64'd1);
        exp_log.push_back(16);
        run_until(1, 20);
        chk("busy_bubble", 64'(busy), 64'd0);
        idle(4);
        check_log("wr_pkt");

        // ports 0 and 15 alternate, 2-beat packets
        rd_len = 2; rd_pkts[0] = 2; rd_pkts[15] = 2;
        exp_log.push_back(0);  exp_log.push_back(15);
        exp_log.push_back(0);  exp_log.push_back(15);
        run_until(4, 60);
        idle(4);
        check_log("rr_order");

        // continuous writes against a pending read on port 3
        wr_len = 1; wr_beat = 0; wr_pkts = 10; rd_len = 1; rd_pkts[3] = 1;
        for (int i = 0; i < 8; i++) exp_log.push_back(16);
        exp_log.push_back(3); exp_log.push_back(16); exp_log.push_back(16);
        run_until(11, 80);
        idle(4);
        check_log("starve");

        // port 5 stalls until its grant times out, port 6 waits
        rd_len = 2; rd_pkts[5] = 1; rd_pkts[6] = 1;
        wait_gnt(5, 20);
        rd_hold[5] = 1'b1;
        repeat (32) begin
            step();
            chk("abort_early", 64'(abort), 64'd0);
        end
        chk("gnt5_held", 64'(rd_gnt), 64'h20);
        step();
        chk("abort_pulse", 64'(abort), 64'd1);
        chk("gnt5_drop", 64'(rd_gnt), 64'd0);
        rd_pkts[5] = 0; rd_hold[5] = 1'b0;
        step();
        chk("abort_once", 64'(abort), 64'd0);
        chk("gnt6_rise", 64'(rd_gnt), 64'h40);
        exp_log.push_back(6);
        run_until(1, 20);
        idle(4);
        check_log("tmo");

        // last beat on the timeout cycle ends the packet normally
        rd_len = 1; rd_pkts[7] = 2; rd_pkts[6] = 1;
        wait_gnt(7, 20);
        rd_hold[7] = 1'b1;
        repeat (32) begin
            step();
            chk("tie_abort_early", 64'(abort), 64'd0);
        end
        rd_hold[7] = 1'b0;
        step();
        chk("tie_abort", 64'(abort), 64'd0);
        chk("tie_gnt_drop", 64'(rd_gnt), 64'd0);
        exp_log.push_back(7); exp_log.push_back(6); exp_log.push_back(7);
        run_until(3, 40);
        idle(4);
        check_log("tie");

        // reset in the middle of a read packet with a strobe in flight
        rd_len = 4; rd_pkts[2] = 1;
        wait_gnt(2, 20);
        step();
        step();
        chk("vld_inflight", 64'(rd_data_vld), 64'h4);
        rst = 1'b0;
        #1;
        chk("rst_outputs", 64'({wr_gnt, rd_gnt, rd_data_vld, sram_en,
                                sram_we, sram_addr, abort, busy}), 64'd0);
        cmd_q.delete();
        vld_q.delete();
        log_q.delete();
        clear_model();
        drive();
        tick();
        tick();
        rst = 1'b1;
        rd_len = 1; rd_pkts[0] = 1; rd_pkts[2] = 1;
        exp_log.push_back(0); exp_log.push_back(2);
        run_until(2, 20);
        idle(4);
        check_log("post_rst");

        idle(4);
        chk("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
        chk("vld_q_empty", 64'(vld_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Sequences the single-port packet SRAM between one write requester (datasg path) and num_of_ports read requesters (per-port read_arbiter instances).
- Grants are packet-granular: a grant is held from the first beat until the beat flagged last.
- Write packets take precedence, bounded by a starvation limit. Read requesters are served round-robin.
- Returns a one-hot read-data-valid strobe aligned to the SRAM read latency.

Parameters:
- num_of_ports, 16, number of read requesters
- port_id_width, 4, width of the read-port index (log2 num_of_ports)
- address_width, 12, SRAM address width
- wr_starve_limit, 8, max consecutive write packets granted while any read is pending
- idle_timeout, 32, cycles a granted requester may hold req low before its grant is aborted
- sram_rd_latency, 1, SRAM clock-to-data latency in cycles

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- wr_req  in  1  write beat request
- wr_addr  in  address_width  write beat address
- wr_last  in  1  final beat of the write packet
- wr_gnt  out  1  write grant, held for the whole packet
- rd_req  in  num_of_ports  per-port read beat request
- rd_addr  in  address_width*num_of_ports  packed per-port read addresses; port i uses bits [i*address_width +: address_width]
- rd_last  in  num_of_ports  final beat of the read packet
- rd_gnt  out  num_of_ports  one-hot read grant, held for the whole packet
- rd_data_vld  out  num_of_ports  one-hot strobe: SRAM data for that port is valid this cycle
- sram_en  out  1  SRAM access enable
- sram_we  out  1  1 = write, 0 = read
- sram_addr  out  address_width  SRAM address
- abort  out  1  one-cycle pulse when a grant is revoked by timeout
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (rst=0, asynchronous) drives every output to 0 and clears all state:
  - state returns to IDLE;
  - rr_ptr is set to num_of_ports-1, so port 0 is first in line;
  - wr_streak and timeout counter are cleared;
  - the rd_data_vld delay pipe is flushed.
- Reset mid-packet drops the grant immediately. Any in-flight rd_data_vld is discarded.
- FSM states: IDLE, WR, RD.
- Decisions are made in IDLE. The resulting grant is registered and visible on the next cycle.
- IDLE -> WR when wr_req=1 and either wr_streak < wr_starve_limit or rd_req == 0.
- IDLE -> RD when the WR condition is not met and rd_req != 0.
  - Winner is the first requesting port at or after (rr_ptr+1) mod num_of_ports, searching upward with wrap.
  - The winner index is latched.
- Beat definition: a beat is req & gnt of the active requester in the same cycle.
- On each beat, the next cycle registers the SRAM command:
  - sram_en=1;
  - sram_we=1 in WR, 0 in RD;
  - sram_addr = the beat address.
- Cycles without a beat drive sram_en=0. sram_addr and sram_we hold their previous values.
- Read data strobe: rd_data_vld[winner] pulses sram_rd_latency cycles after the sram_en read cycle (2 cycles after the beat when latency is 1). Implemented as a shift pipe carrying the port index and a valid bit.
- Packet end: a beat with last=1 returns the FSM to IDLE on the next cycle and drops gnt. This gives exactly one bubble cycle between packets.
- wr_streak on packet end:
  - +1 at a WR packet end, saturating at wr_starve_limit;
  - cleared to 0 at an RD packet end;
  - cleared to 0 whenever the FSM is in IDLE with rd_req == 0.
- rr_ptr on packet end: updated to the winner index at an RD packet end only.
- Timeout:
  - In WR/RD, the counter increments on each cycle where the active req=0, and clears on a beat.
  - When it reaches idle_timeout: abort pulses for 1 cycle, gnt drops, and the FSM goes to IDLE.
  - rr_ptr/wr_streak are updated as for a normal packet end.
- A last=1 beat arriving in the same cycle the timeout hits counts as a normal packet end; abort stays 0.
- Requests from non-granted requesters are ignored while busy. No preemption.
- A write and reads arriving in the same IDLE cycle follow the precedence rules above.

Decomposition:
- Shared package (sram_ctl_pkg):
  - state encoding constants: ST_IDLE=2'd0, ST_WR=2'd1, ST_RD=2'd2;
  - address_width and port_id_width defaults, shared with datasg and read_arbiter.
- One natural sub-module: rr_pick.
  - Combinational round-robin first-set search.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot winner, index, any.

Test Plan:
- Reset release with wr_req=1, wr_addr=0x010, a 3-beat packet with last on beat 3:
  - wr_gnt rises 1 cycle after the request;
  - sram_we=1 at addresses 0x010, 0x011, 0x012 on consecutive cycles;
  - gnt drops after the last beat, then one bubble cycle.
- rd_req=16'h8001, each port sending 2-beat packets:
  - grants go port 0, then 15, then 0;
  - rd_data_vld[0] pulses 2 cycles after each port-0 beat;
  - never more than one rd_data_vld bit high.
- wr_req held continuously (1-beat packets) with rd_req[3]=1:
  - exactly 8 write packets are granted, then port 3;
  - writes resume afterwards with wr_streak=0.
- Port 5 granted, then rd_req[5]=0 for 32 cycles:
  - abort pulses once at cycle 32 and rd_gnt[5] drops;
  - next pending port 6 is granted 2 cycles later.
- Assert rst=0 mid-RD packet while a read strobe is in flight:
  - all outputs are 0 in the same cycle;
  - no rd_data_vld appears after rst is released;
  - first grant after release goes to port 0.
- rd_last and timeout hit on the same cycle:
  - abort=0;
  - normal packet end with rr_ptr updated.
